// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// One operation in flight: accept, issue, wait for result or timeout, hold response.
module alu_arbiter #(
   parameter int BUS_WIDTH    = 32,
   parameter int OPCODE_WIDTH = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [2*OPCODE_WIDTH-1:0] req_opcode,
   input  logic [2*BUS_WIDTH-1:0]    req_rs_data,
   input  logic [2*BUS_WIDTH-1:0]    req_imme_rs,
   output logic [1:0]                rsp_valid,
   input  logic [1:0]                rsp_ready,
   output logic [BUS_WIDTH-1:0]      rsp_data,
   output logic                      rsp_err,
   output logic                      alu_start,
   output logic [OPCODE_WIDTH-1:0]   alu_opcode,
   output logic [BUS_WIDTH-1:0]      alu_rs_data,
   output logic [BUS_WIDTH-1:0]      alu_imme_rs,
   input  logic [BUS_WIDTH-1:0]      alu_data_out,
   input  logic                      alu_data_valid
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    owner;
   logic                    last_served;
   logic                    grant_idx;
   logic                    grant_any;
   logic                    accept;
   logic                    done_valid;
   logic                    done_timeout;
   logic [7:0]              timer;
   logic [OPCODE_WIDTH-1:0] op_reg;
   logic [BUS_WIDTH-1:0]    rs_reg;
   logic [BUS_WIDTH-1:0]    imm_reg;
   logic [BUS_WIDTH-1:0]    data_reg;
   logic                    err_reg;

   // Round-robin: on a tie the requester not served last wins.
   always_comb begin
      grant_any = |req_valid;
      grant_idx = 1'b0;
      if (req_valid == 2'b11) begin
         grant_idx = ~last_served;
      end else if (req_valid[1]) begin
         grant_idx = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      req_ready    = 2'b00;
      rsp_valid    = 2'b00;
      alu_start    = 1'b0;
      accept       = 1'b0;
      done_valid   = 1'b0;
      done_timeout = 1'b0;
      case (state)
         IDLE: begin
            // Gated by rst so req_ready reads 0 while reset is held.
            if (grant_any && !rst) begin
               req_ready[grant_idx] = 1'b1;
               accept               = 1'b1;
               state_next           = ISSUE;
            end
         end
         ISSUE: begin
            alu_start  = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (alu_data_valid) begin
               done_valid = 1'b1;
               state_next = RESP;
            end else if (timer == 8'(TIMEOUT - 1)) begin
               done_timeout = 1'b1;
               state_next   = RESP;
            end
         end
         RESP: begin
            rsp_valid[owner] = 1'b1;
            if (rsp_ready[owner]) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Timer counts WAIT cycles already elapsed, so the TIMEOUT-th WAIT cycle is the last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner       <= 1'b0;
         last_served <= 1'b1;
         timer       <= 8'd0;
         op_reg      <= '0;
         rs_reg      <= '0;
         imm_reg     <= '0;
         data_reg    <= '0;
         err_reg     <= 1'b0;
      end else begin
         if (accept) begin
            owner       <= grant_idx;
            last_served <= grant_idx;
            op_reg      <= grant_idx ? req_opcode[2*OPCODE_WIDTH-1:OPCODE_WIDTH]
                                     : req_opcode[OPCODE_WIDTH-1:0];
            rs_reg      <= grant_idx ? req_rs_data[2*BUS_WIDTH-1:BUS_WIDTH]
                                     : req_rs_data[BUS_WIDTH-1:0];
            imm_reg     <= grant_idx ? req_imme_rs[2*BUS_WIDTH-1:BUS_WIDTH]
                                     : req_imme_rs[BUS_WIDTH-1:0];
         end
         if (state == ISSUE) begin
            timer <= 8'd0;
         end else if (state == WAIT) begin
            timer <= timer + 8'd1;
         end
         if (done_valid) begin
            data_reg <= alu_data_out;
            err_reg  <= 1'b0;
         end else if (done_timeout) begin
            data_reg <= '0;
            err_reg  <= 1'b1;
         end
      end
   end

   assign alu_opcode  = op_reg;
   assign alu_rs_data = rs_reg;
   assign alu_imme_rs = imm_reg;
   assign rsp_data    = data_reg;
   assign rsp_err     = err_reg;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 4, ALU opcode width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles waiting for ALU result (range 2..255).
REQ-004 SHALL be clocked by a single clock and reset by an asynchronous, active-high reset.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  2  requester n presents an ALU operation.
REQ-008 req_ready  output  2  arbiter accepts requester n's operation this cycle.
REQ-009 req_opcode  input  2*OPCODE_WIDTH  packed opcodes, slice n for requester n.
REQ-010 req_rs_data  input  2*BUS_WIDTH  packed register operands.
REQ-011 req_imme_rs  input  2*BUS_WIDTH  packed immediate operands.
REQ-012 rsp_valid  output  2  result available for requester n.
REQ-013 rsp_ready  input  2  requester n consumes result.
REQ-014 rsp_data  output  BUS_WIDTH  result, shared, qualified by rsp_valid.
REQ-015 rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-016 alu_start  output  1  one-cycle issue strobe to ALU.
REQ-017 alu_opcode  output  OPCODE_WIDTH  opcode driven to ALU.
REQ-018 alu_rs_data  output  BUS_WIDTH  register operand driven to ALU.
REQ-019 alu_imme_rs  output  BUS_WIDTH  immediate operand driven to ALU.
REQ-020 alu_data_out  input  BUS_WIDTH  ALU result.
REQ-021 alu_data_valid  input  1  ALU result valid.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight max.
REQ-023 IDLE: req_ready[n]=1 only for the granted requester n with req_valid[n]=1; at most one bit set.
REQ-024 Grant SHALL be round-robin: if both valid, grant the requester not served last; if one valid, grant it.
REQ-025 Transfer on req_valid[n]&req_ready[n]: latch opcode/operands, record owner n, update last-served pointer, go ISSUE.
REQ-026 ISSUE: alu_start=1 for exactly one cycle with latched operands on alu_* outputs; go WAIT; timer cleared.
REQ-027 WAIT: alu_* operands held stable; timer increments each cycle; alu_data_valid=1 captures alu_data_out, rsp_err=0, go RESP.
REQ-028 WAIT: timer reaching TIMEOUT without alu_data_valid SHALL go RESP with rsp_data=0, rsp_err=1.
REQ-029 alu_data_valid and timeout in same cycle SHALL take the result (valid wins, rsp_err=0).
REQ-030 alu_data_valid in IDLE, ISSUE or RESP SHALL be ignored.
REQ-031 RESP: rsp_valid[owner]=1, rsp_data/rsp_err stable until rsp_ready[owner]=1; then IDLE same edge; rsp_ready of the other requester ignored.
REQ-032 Latency: accept at edge T -> alu_start during cycle T+1 -> ALU valid at cycle T+1+k (k>=1) -> rsp_valid from cycle T+2+k.
REQ-033 Back-to-back throughput SHALL be one operation per 4 cycles minimum (accept, issue, wait>=1, resp).
REQ-034 Requester dropping req_valid without handshake SHALL cause no state change.

Reset
REQ-035 rst=1 SHALL immediately force state IDLE, timer 0, last-served pointer = requester 1 (requester 0 wins first tie).
REQ-036 During reset all outputs SHALL be 0: req_ready, rsp_valid, rsp_data, rsp_err, alu_start, alu_opcode, alu_rs_data, alu_imme_rs.
REQ-037 Reset mid-operation SHALL discard the in-flight operation; no response is ever issued for it.

Verification
REQ-038 Single op: req0 opcode=0, rs=5, imm=7; ALU valid 2 cycles after alu_start with 12 -> rsp_valid[0]=1, rsp_data=12, rsp_err=0.
REQ-039 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; never both req_ready set.
REQ-040 Timeout: TIMEOUT=16, ALU never valid -> rsp_valid=1, rsp_err=1, rsp_data=0 after 16 WAIT cycles.
REQ-041 Backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_data/rsp_err stable, req_ready=0 throughout, IDLE on 6th.
REQ-042 Reset in WAIT: assert rst -> all outputs 0 immediately; late ALU valid ignored; no rsp_valid after release.
